// File: rtl/sd_image_pkg.sv
// Shared state encoding, sector geometry and LBA range helper for the image responder.
package sd_image_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int BUF_AW       = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_MEM,
    ST_RD_WAIT,
    ST_RD_PUT,
    ST_WR_ADDR,
    ST_WR_MEM,
    ST_DONE
  } state_t;

  // An LBA fits when no bit at or above the image's sector-index width is set.
  function automatic logic lba_in_range(input logic [63:0] lba, input int img_aw);
    return (lba >> (img_aw - BUF_AW)) == 64'd0;
  endfunction

endpackage

// File: rtl/sd_image_responder.sv
// Serves sector read/write requests by moving 512 bytes between the sector buffer
// and a byte-addressed image memory, one memory handshake per byte.
module sd_image_responder
  import sd_image_pkg::*;
#(
  parameter int IMG_AW = 20,
  parameter int LBA_W  = 32
) (
  input  logic              clk_100m,
  input  logic              reset_n,
  input  logic [LBA_W-1:0]  sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [BUF_AW-1:0] sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic              mem_req,
  output logic              mem_we,
  output logic [IMG_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic              lba_err
);

  localparam int LBA_KEEP = IMG_AW - BUF_AW;

  state_t              r_state;
  logic [BUF_AW-1:0]   r_off;
  logic [LBA_KEEP-1:0] r_lba;
  logic                r_oor;

  logic [BUF_AW-1:0]   w_off_nxt;
  logic                w_last;
  logic                w_in_range;

  assign w_off_nxt  = r_off + BUF_AW'(1);
  assign w_last     = (r_off == BUF_AW'(SECTOR_BYTES - 1));
  assign w_in_range = lba_in_range(64'(sd_lba), IMG_AW);

  always_ff @(posedge clk_100m) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_off        <= '0;
      r_lba        <= '0;
      r_oor        <= 1'b0;
      sd_ack       <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      sd_buff_wr   <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      lba_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (sd_rd || sd_wr) begin
            r_lba   <= sd_lba[LBA_KEEP-1:0];
            r_oor   <= !w_in_range;
            lba_err <= !w_in_range;
            r_off   <= '0;
            sd_ack  <= 1'b1;
            if (sd_rd) begin
              if (w_in_range) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {sd_lba[LBA_KEEP-1:0], BUF_AW'(0)};
                r_state  <= ST_RD_MEM;
              end else begin
                // Out-of-range read skips memory and streams zeros into the buffer.
                sd_buff_wr   <= 1'b1;
                sd_buff_addr <= '0;
                sd_buff_dout <= 8'h00;
                r_state      <= ST_RD_PUT;
              end
            end else begin
              r_state <= ST_WR_ADDR;
            end
          end
        end

        ST_RD_MEM: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            r_state <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (mem_rvalid) begin
            sd_buff_wr   <= 1'b1;
            sd_buff_addr <= r_off;
            sd_buff_dout <= mem_rdata;
            r_state      <= ST_RD_PUT;
          end
        end

        ST_RD_PUT: begin
          if (w_last) begin
            sd_buff_wr <= 1'b0;
            sd_ack     <= 1'b0;
            r_state    <= ST_DONE;
          end else begin
            r_off <= w_off_nxt;
            if (r_oor) begin
              sd_buff_addr <= w_off_nxt;
              sd_buff_dout <= 8'h00;
            end else begin
              sd_buff_wr <= 1'b0;
              mem_req    <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= {r_lba, w_off_nxt};
              r_state    <= ST_RD_MEM;
            end
          end
        end

        // The buffer address already pointed at r_off last cycle, so din is current here.
        ST_WR_ADDR: begin
          mem_wdata <= sd_buff_din;
          mem_req   <= !r_oor;
          mem_we    <= 1'b1;
          mem_addr  <= {r_lba, r_off};
          if (!w_last) sd_buff_addr <= w_off_nxt;
          r_state   <= ST_WR_MEM;
        end

        ST_WR_MEM: begin
          if (mem_ready || r_oor) begin
            mem_req <= 1'b0;
            if (w_last) begin
              sd_ack  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_off   <= w_off_nxt;
              r_state <= ST_WR_ADDR;
            end
          end
        end

        // Park the buffer address at 0 so a following write sees byte 0 on din at accept.
        ST_DONE: begin
          sd_buff_addr <= '0;
          r_state      <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sd_image_responder.md
Name: sd_image_responder

Overview:
- Block-device side of the sector-buffer protocol. It answers sd_rd/sd_wr sector requests from the core.
- It fills or drains the 512-byte sector dpram through its port A (sd_buff_addr/sd_buff_dout/sd_buff_wr/sd_buff_din).
- Data moves to and from a byte-addressed image memory (BRAM or SDRAM controller).
- Used for standalone/simulation builds in place of the HPS SD path; plugs into the same sdbuf wiring.

Parameters:
- IMG_AW, 20: image byte-address width; image holds 2^(IMG_AW-9) sectors.
- LBA_W, 32: width of sd_lba.

Ports:
- clk_100m  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- sd_lba  in  LBA_W  sector number; sampled on request accept.
- sd_rd  in  1  request: image -> buffer (sector read).
- sd_wr  in  1  request: buffer -> image (sector write).
- sd_ack  out  1  high for the whole transfer.
- sd_buff_addr  out  9  sector-buffer byte index.
- sd_buff_dout  out  8  byte written into the buffer.
- sd_buff_wr  out  1  buffer write strobe.
- sd_buff_din  in  8  buffer read data; valid 1 cycle after sd_buff_addr.
- mem_req  out  1  image access request; held until mem_ready.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  out  IMG_AW  image byte address = {lba[IMG_AW-10:0], offset}.
- mem_wdata  out  8  image write data.
- mem_ready  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; arrives exactly once per accepted read, ≥1 cycle after accept.
- mem_rdata  in  8  read data.
- lba_err  out  1  sticky: last transfer's LBA was out of range.

Behaviour:
- Reset (reset_n=0 at clock edge), any state: FSM → IDLE. Outputs: sd_ack=0, sd_buff_wr=0, mem_req=0, mem_we=0, sd_buff_addr=0, sd_buff_dout=0, mem_addr=0, mem_wdata=0, lba_err=0. An in-flight transfer is abandoned; a stale mem_rvalid after reset is ignored.
- States: IDLE, RD_MEM, RD_WAIT, RD_PUT, WR_ADDR, WR_MEM, DONE.
- IDLE:
  - sd_rd=1 → latch lba/op, sd_ack=1 next cycle, offset=0, go RD_MEM.
  - sd_rd=0, sd_wr=1 → same latch, go WR_ADDR.
  - Both high → read wins.
- Range check on accept: out of range = any lba bit at or above position IMG_AW-9 is set. lba_err is updated at each accept.
  - Out-of-range read: buffer filled with 0x00, no mem traffic.
  - Out-of-range write: buffer scanned, no mem writes.
- Read path, per byte:
  - RD_MEM: mem_req=1, mem_we=0 until mem_ready → RD_WAIT.
  - RD_WAIT: wait for mem_rvalid → RD_PUT.
  - RD_PUT: sd_buff_addr=offset, sd_buff_dout=mem_rdata, sd_buff_wr=1 for exactly one cycle.
  - offset==511 → DONE, else offset+1 → RD_MEM.
- Write path, per byte:
  - WR_ADDR: sd_buff_addr=offset.
  - Next cycle: sample sd_buff_din into mem_wdata → WR_MEM.
  - WR_MEM: mem_req=1, mem_we=1 until mem_ready.
  - offset==511 → DONE, else offset+1 → WR_ADDR.
- sd_buff_wr is never asserted during a write transfer.
- DONE: sd_ack=0, wait 1 cycle → IDLE.
  - Requests are ignored while sd_ack=1 or in DONE.
  - An initiator still holding sd_rd/sd_wr after ack falls starts a new transfer (initiator must drop its request on ack).
- sd_lba changes during a transfer have no effect.
- Offset is 9 bits and counts exactly 512 bytes; no wrap past 511.
- Minimum latency with mem_ready and mem_rvalid both immediate:
  - Read: 3 cycles/byte. Accept to ack-fall = 1 + 1536 + 1 cycles.
  - Write: 2 cycles/byte.

Decomposition:
- Package sd_image_pkg:
  - state enum.
  - SECTOR_BYTES=512, BUF_AW=9.
  - Function lba_in_range(lba, IMG_AW).
- No sub-module. The FSM plus offset counter is a single module of roughly 200 lines.

Test Plan:
- Read, in range: image byte at addr = lba*512+i preloaded with (i^lba)&0xFF; sd_rd pulse with lba=3 → sd_ack rises the cycle after accept; 512 sd_buff_wr strobes at addresses 0..511 with data (i^3)&0xFF; ack falls; lba_err=0.
- Write, in range: buffer preloaded with 0xA5^i; sd_wr with lba=5 → 512 mem writes to 0xA00..0xBFF with the matching data; sd_buff_wr never high.
- Out of range (IMG_AW=20): sd_rd with lba=2048 → 512 writes of 0x00, zero mem_req cycles, lba_err=1. A following in-range read clears lba_err.
- Backpressure: mem_ready asserted every 3rd cycle and mem_rvalid delayed 4 cycles → data is still correct; mem_req/mem_we/mem_addr stay stable until accept.
- Simultaneous request: sd_rd=sd_wr=1 in the same cycle → read performed. Request held through a transfer → no second accept while ack is high.
- Reset mid-transfer: reset_n=0 at byte 100 of a read → all outputs reach reset values at the next edge. A subsequent read completes with the full 512 bytes.
